// File: rtl/rns_mod_pkg.sv
// Shared constants and helpers for the RNS forward-converter finalize stages
// (32/17/13/11 channels).
package rns_mod_pkg;

   localparam int M32 = 32;
   localparam int M17 = 17;
   localparam int M13 = 13;
   localparam int M11 = 11;

   // Smallest r with 2**r >= v; residue 0..v-1 fits in r bits.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Partial-sum widths from the folding reducers (each satisfies 2**IN_W-1 < 6*MOD).
   localparam int IN_W_17 = 6;
   localparam int IN_W_13 = 6;
   localparam int IN_W_11 = 6;

   localparam int RES_W_32 = clog2(M32);
   localparam int RES_W_17 = clog2(M17);
   localparam int RES_W_13 = clog2(M13);
   localparam int RES_W_11 = clog2(M11);

endpackage

// File: rtl/residue_finalize_mod_11_if.sv
// Stream bundle for the mod-11 finalize stage: partial sum in, canonical residue out,
// each with valid/ready and a sideband tag.
interface residue_finalize_mod_11_if
   import rns_mod_pkg::*;
#(
   parameter int IN_W  = IN_W_11,
   parameter int OUT_W = RES_W_11,
   parameter int TAG_W = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_sum;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_res;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_sum, in_tag, out_ready,
      output in_ready, out_valid, out_res, out_zero, out_tag
   );

   modport master (
      output in_valid, in_sum, in_tag, out_ready,
      input  in_ready, out_valid, out_res, out_zero, out_tag
   );

endinterface

// File: rtl/residue_finalize_mod_11_mod_sub_stage.sv
// Registered conditional subtract of K with valid/ready and a pass-through tag.
// Shared by the 11, 13 and 17 finalize channels as their last stage.
module mod_sub_stage #(
   parameter int VAL_W = 5,
   parameter int K     = 11,
   parameter int OUT_W = 4,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [VAL_W-1:0] in_val_i,
   input  logic [TAG_W-1:0] in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_val_o,
   output logic             out_zero_o,
   output logic [TAG_W-1:0] out_tag_o
);

   logic             valid_q;
   logic [OUT_W-1:0] val_q;
   logic             zero_q;
   logic [TAG_W-1:0] tag_q;
   logic [VAL_W-1:0] diff_d;
   logic [OUT_W-1:0] val_d;
   logic             load;

   assign in_ready_o = !valid_q || out_ready_i;
   assign load       = in_valid_i && in_ready_o;

   // Input is below 2*K, so a single conditional subtract lands in 0..K-1.
   always_comb begin
      diff_d = in_val_i;
      if (in_val_i >= VAL_W'(K)) begin
         diff_d = in_val_i - VAL_W'(K);
      end
      val_d = OUT_W'(diff_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         val_q   <= '0;
         zero_q  <= 1'b0;
         tag_q   <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         val_q   <= val_d;
         zero_q  <= (val_d == '0);
         tag_q   <= in_tag_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign out_val_o   = val_q;
   assign out_zero_o  = zero_q;
   assign out_tag_o   = tag_q;

endmodule

// File: rtl/residue_finalize_mod_11.sv
// Canonicalises the mod-11 reducer's 6-bit partial sum into 0..10 with a two-stage
// compare-subtract pipeline (fold by 44/22, then by 11) under valid/ready flow control.
module residue_finalize_mod_11
   import rns_mod_pkg::*;
#(
   parameter int MOD   = M11,
   parameter int IN_W  = IN_W_11,
   parameter int OUT_W = RES_W_11,
   parameter int TAG_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   residue_finalize_mod_11_if.slave    bus
);

   localparam int S1_W = OUT_W + 1;
   localparam logic [IN_W-1:0] FOUR_K = IN_W'(4 * MOD);
   localparam logic [IN_W-1:0] TWO_K  = IN_W'(2 * MOD);

   if ((2 ** IN_W) - 1 >= 6 * MOD) begin : gInWidthCheck
      $fatal(1, "IN_W too wide: partial sum may reach 6*MOD");
   end
   if ((2 ** OUT_W) <= MOD - 1) begin : gOutWidthCheck
      $fatal(1, "OUT_W too narrow to hold MOD-1");
   end

   logic             s1Valid_q;
   logic [S1_W-1:0]  s1Val_q;
   logic [S1_W-1:0]  s1Val_d;
   logic [TAG_W-1:0] s1Tag_q;
   logic             s2Ready;
   logic             inAccept;

   assign bus.in_ready = !s1Valid_q || s2Ready;
   assign inAccept     = bus.in_valid && bus.in_ready;

   // Priority fold: 0..63 collapses to 0..2*MOD-1 without any underflow path.
   always_comb begin
      s1Val_d = S1_W'(bus.in_sum);
      if (bus.in_sum >= FOUR_K) begin
         s1Val_d = S1_W'(bus.in_sum - FOUR_K);
      end else if (bus.in_sum >= TWO_K) begin
         s1Val_d = S1_W'(bus.in_sum - TWO_K);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1Val_q   <= '0;
         s1Tag_q   <= '0;
      end else if (inAccept) begin
         s1Valid_q <= 1'b1;
         s1Val_q   <= s1Val_d;
         s1Tag_q   <= bus.in_tag;
      end else if (s2Ready) begin
         s1Valid_q <= 1'b0;
      end
   end

   mod_sub_stage #(
      .VAL_W (S1_W),
      .K     (MOD),
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
   ) uStage2 (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (s1Valid_q),
      .in_ready_o  (s2Ready),
      .in_val_i    (s1Val_q),
      .in_tag_i    (s1Tag_q),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_val_o   (bus.out_res),
      .out_zero_o  (bus.out_zero),
      .out_tag_o   (bus.out_tag)
   );

   resCanonical: assert property (@(posedge clk) disable iff (rst)
      bus.out_valid |-> (bus.out_res < OUT_W'(MOD)));

endmodule

// File: tb/tb_residue_finalize_mod_11.sv
// Bench for residue_finalize_mod_11: directed boundary/backpressure/reset cases plus
// random valid/ready traffic checked against an in-order queue model of x % 11.
module tb_residue_finalize_mod_11;

   localparam int MOD   = 11;
   localparam int IN_W  = 6;
   localparam int OUT_W = 4;
   localparam int TAG_W = 8;
   localparam int RANDOM_BEATS = 10000;

   typedef struct {
      int res;
      int tag;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t q[$];

   logic             prevStalled = 1'b0;
   logic [OUT_W-1:0] prevRes;
   logic             prevZero;
   logic [TAG_W-1:0] prevTag;
   logic             expValid;
   exp_t             head;
   exp_t             incoming;

   always #5 clk = ~clk;

   residue_finalize_mod_11_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

   residue_finalize_mod_11 #(
      .MOD   (MOD),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         if (failures <= 40) begin
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
         end
      end
   endtask

   task automatic applyStimulus(input logic valid, input int sum, input int tag, input logic rdy);
      @(posedge clk);
      #1;
      bus.in_valid  = valid;
      bus.in_sum    = IN_W'(sum);
      bus.in_tag    = TAG_W'(tag);
      bus.out_ready = rdy;
   endtask

   // Reference: every accepted beat leaves in order as sum % 11, two cycles after
   // acceptance at the earliest; at most two beats can be in flight.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         prevStalled = 1'b0;
      end else begin
         expValid = (q.size() >= 2) || (q.size() == 1 && q[0].cyc <= cyc - 2);
         checkOutput("model_out_valid", {31'd0, bus.out_valid}, {31'd0, expValid});
         checkOutput("model_in_ready", {31'd0, bus.in_ready}, {31'd0, (q.size() < 2) || bus.out_ready});
         if (prevStalled) begin
            checkOutput("stall_hold_res", {28'd0, bus.out_res}, {28'd0, prevRes});
            checkOutput("stall_hold_zero", {31'd0, bus.out_zero}, {31'd0, prevZero});
            checkOutput("stall_hold_tag", {24'd0, bus.out_tag}, {24'd0, prevTag});
         end
         if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               if (failures <= 40) begin
                  $display("[TB] FAIL model_spurious_output: got tag %0d expected no output", bus.out_tag);
               end
            end else begin
               head = q[0];
               checkOutput("model_out_res", {28'd0, bus.out_res}, head.res);
               checkOutput("model_out_zero", {31'd0, bus.out_zero}, (head.res == 0) ? 32'd1 : 32'd0);
               checkOutput("model_out_tag", {24'd0, bus.out_tag}, head.tag);
               if (bus.out_ready) void'(q.pop_front());
            end
         end
         prevStalled = bus.out_valid && !bus.out_ready;
         prevRes     = bus.out_res;
         prevZero    = bus.out_zero;
         prevTag     = bus.out_tag;
         if (bus.in_valid && bus.in_ready) begin
            incoming.res = int'(bus.in_sum) % MOD;
            incoming.tag = int'(bus.in_tag);
            incoming.cyc = cyc;
            q.push_back(incoming);
         end
      end
   end

   int sweepIn[8]   = '{0, 10, 11, 21, 22, 43, 44, 63};
   int sweepRes[8]  = '{0, 10, 0, 10, 0, 10, 0, 8};
   int sweepZero[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

   initial begin
      int   sent;
      int   budget;
      logic pending;
      int   curSum;
      int   curTag;

      bus.in_valid  = 1'b0;
      bus.in_sum    = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 0);
      checkOutput("reset_out_res", {28'd0, bus.out_res}, 0);
      checkOutput("reset_out_zero", {31'd0, bus.out_zero}, 0);
      checkOutput("reset_out_tag", {24'd0, bus.out_tag}, 0);
      checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 1);

      // Boundary sweep with literal expectations, two cycles of latency.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i < 8, (i < 8) ? sweepIn[i] : 0, i, 1'b1);
         @(negedge clk);
         if (i >= 2) begin
            checkOutput("sweep_valid", {31'd0, bus.out_valid}, 1);
            checkOutput("sweep_res", {28'd0, bus.out_res}, sweepRes[i-2]);
            checkOutput("sweep_zero", {31'd0, bus.out_zero}, sweepZero[i-2]);
            checkOutput("sweep_tag", {24'd0, bus.out_tag}, i - 2);
         end
      end

      // Exhaustive back-to-back input space.
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'b1, i, i, 1'b1);
         @(negedge clk);
         checkOutput("exh_in_ready", {31'd0, bus.in_ready}, 1);
      end
      repeat (4) applyStimulus(1'b0, 0, 0, 1'b1);

      // Backpressure: two beats fill the pipe, the third waits.
      applyStimulus(1'b1, 5, 1, 1'b0);
      @(negedge clk);
      checkOutput("bp_ready_first", {31'd0, bus.in_ready}, 1);
      applyStimulus(1'b1, 12, 2, 1'b0);
      @(negedge clk);
      checkOutput("bp_ready_second", {31'd0, bus.in_ready}, 1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 33, 3, 1'b0);
         @(negedge clk);
         checkOutput("bp_ready_full", {31'd0, bus.in_ready}, 0);
         checkOutput("bp_hold_valid", {31'd0, bus.out_valid}, 1);
         checkOutput("bp_hold_res", {28'd0, bus.out_res}, 5);
         checkOutput("bp_hold_tag", {24'd0, bus.out_tag}, 1);
      end
      applyStimulus(1'b1, 33, 3, 1'b1);
      @(negedge clk);
      checkOutput("bp_rel_res0", {28'd0, bus.out_res}, 5);
      checkOutput("bp_rel_tag0", {24'd0, bus.out_tag}, 1);
      checkOutput("bp_rel_ready", {31'd0, bus.in_ready}, 1);
      applyStimulus(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("bp_rel_res1", {28'd0, bus.out_res}, 1);
      checkOutput("bp_rel_tag1", {24'd0, bus.out_tag}, 2);
      applyStimulus(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("bp_rel_res2", {28'd0, bus.out_res}, 0);
      checkOutput("bp_rel_zero2", {31'd0, bus.out_zero}, 1);
      checkOutput("bp_rel_tag2", {24'd0, bus.out_tag}, 3);
      applyStimulus(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("bp_drained", {31'd0, bus.out_valid}, 0);

      // Full pipe, then accept and consume in the same cycle.
      applyStimulus(1'b1, 50, 10, 1'b0);
      applyStimulus(1'b1, 51, 11, 1'b0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 52 + k, 12 + k, 1'b1);
         @(negedge clk);
         checkOutput("sim_in_ready", {31'd0, bus.in_ready}, 1);
         checkOutput("sim_out_valid", {31'd0, bus.out_valid}, 1);
         checkOutput("sim_out_tag", {24'd0, bus.out_tag}, 10 + k);
         checkOutput("sim_out_res", {28'd0, bus.out_res}, (50 + k) % MOD);
      end
      repeat (4) applyStimulus(1'b0, 0, 0, 1'b1);

      // Reset with both stages holding data.
      applyStimulus(1'b1, 63, 20, 1'b0);
      applyStimulus(1'b1, 43, 21, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_out_valid", {31'd0, bus.out_valid}, 0);
      checkOutput("rst_mid_in_ready", {31'd0, bus.in_ready}, 1);
      checkOutput("rst_mid_out_res", {28'd0, bus.out_res}, 0);
      checkOutput("rst_mid_out_tag", {24'd0, bus.out_tag}, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 0, 0, 1'b1);
         @(negedge clk);
         checkOutput("rst_no_stale", {31'd0, bus.out_valid}, 0);
      end

      // Random valid/ready traffic against the queue model.
      sent    = 0;
      budget  = 0;
      pending = 1'b0;
      curSum  = 0;
      curTag  = 0;
      while (sent < RANDOM_BEATS && budget < 60000) begin
         @(posedge clk);
         #1;
         if (!pending && $urandom_range(9) < 7) begin
            pending = 1'b1;
            curSum  = int'($urandom_range(63));
            curTag  = int'($urandom_range(255));
         end
         bus.in_valid  = pending;
         bus.in_sum    = IN_W'(curSum);
         bus.in_tag    = TAG_W'(curTag);
         bus.out_ready = ($urandom_range(9) < 6);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) begin
            pending = 1'b0;
            sent++;
         end
         budget++;
      end
      checkOutput("random_beats_sent", sent, RANDOM_BEATS);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("drain_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/residue_finalize_mod_11.md
Name: residue_finalize_mod_11

Overview:
- Downstream stage of the mod-11 half-period folding reducer.
- Takes the reducer's 6-bit partially reduced sum, which is congruent to N mod 11 but not canonical (range 0..63).
- Produces the canonical residue 0..10 for the 11-channel of the 32/17/13/11 RNS forward converter.
- Two-stage pipelined compare-subtract with valid/ready flow control and an opaque sideband tag carried in lockstep.

Parameters:
- MOD, 11, modulus of this channel.
- IN_W, 6, width of the partial-sum input; constraint 2^IN_W-1 < 6*MOD (elaboration-time check, fatal if violated).
- OUT_W, 4, residue width; constraint 2^OUT_W > MOD-1.
- TAG_W, 8, sideband tag width, passed through unmodified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_sum/in_tag valid
- in_ready  output  1  stage can accept this cycle
- in_sum  input  IN_W  partial residue, congruent to N mod MOD
- in_tag  input  TAG_W  sideband
- out_valid  output  1  out_res/out_tag/out_zero valid
- out_ready  input  1  consumer accepts
- out_res  output  OUT_W  canonical residue 0..MOD-1
- out_zero  output  1  out_res == 0
- out_tag  output  TAG_W  tag matching out_res

Behaviour:
- Reset values: out_valid=0, out_res=0, out_zero=0, out_tag=0, internal s1_valid=0, s1 data=0.
- in_ready is combinational: !s1_valid || (!s2_valid || out_ready). It is never registered, so there are no bubbles at full throughput.
- Stage 1, on an accepted beat (in_valid && in_ready):
  - x >= 4*MOD: s1 = x-4*MOD.
  - else x >= 2*MOD: s1 = x-2*MOD.
  - else s1 = x.
  - Result range 0..2*MOD-1, width OUT_W+1.
- Stage 2, on advance: if s1 >= MOD then res = s1-MOD, else res = s1. Register res, (res==0) and the tag into the outputs.
- Advance rules:
  - s2 loads when s1_valid && (!out_valid || out_ready).
  - s1 loads when the input is accepted. s1_valid clears when s1 advances with no new input.
- Latency: an accepted input appears on out_* exactly 2 cycles later when unstalled. Throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, out_res/out_zero/out_tag hold stable. The s1 register still fills. in_ready falls only when both stages hold data.
- Simultaneous out consume and in accept with both stages full: shift both stages in the same cycle; no loss, no duplication.
- Data ordering is strictly FIFO; tags never reorder.
- Reset mid-operation: all in-flight beats are discarded and the outputs return to reset values on the next edge. in_ready=1 in the first cycle after reset deasserts.
- Arithmetic: all compares unsigned at IN_W bits; subtractions cannot underflow, by construction.
- Out-of-range inputs cannot occur given the constraint.
- Simulation-only assertion: out_valid implies out_res < MOD.

Decomposition:
- Shared package rns_mod_pkg holds:
  - modulus constants M32=32, M17=17, M13=13, M11=11;
  - per-channel partial-sum widths (IN_W) and residue widths;
  - a width function clog2 used by all finalize stages.
- One natural sub-module: mod_sub_stage (parameters VAL_W, K). It performs a registered conditional subtract with valid/ready and a tag.
  - Stage 1 uses two instances-worth of constants via a priority compare.
  - Stage 2 instantiates it with K=MOD.
  - The same sub-module serves the 13 and 17 channels.

Test Plan:
- Boundary sweep, out_ready=1: in_sum 0,10,11,21,22,43,44,63 -> out_res 0,10,0,10,0,10,0,8 two cycles later; out_zero=1 on 0,11,22,44.
- Exhaustive: all 64 in_sum with incrementing tags, back-to-back -> out_res == in_sum % 11, tag order preserved, one output per cycle.
- Backpressure: out_ready=0, send 5 (tag 1), 12 (tag 2), 33 (tag 3):
  - in_ready drops after two accepts and tag 3 waits;
  - outputs hold 5/tag 1;
  - releasing out_ready yields 5,1,0 with tags 1,2,3 in consecutive cycles.
- Random in_valid/out_ready toggling over 10k beats -> scoreboard matches in_sum % 11; no drops or duplicates; outputs stable while stalled.
- Reset with both stages full (in-flight 63 and 43): assert rst 1 cycle -> out_valid=0 next cycle, in_ready=1, no stale outputs afterwards.
- Simultaneous accept and consume with pipeline full -> in_ready stays 1, outputs advance every cycle.
